// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, register index and memory-stage FSM state.
// Purely declarative, so it has no latency.
// No backpressure: this file only carries types.
package cpu_types_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [REG_W-1:0]  regbits_t;

    // Data-request sequencing for the memory stage.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } memstate_t;

endpackage

// File: rtl/iexec_mmem.sv
// EX/MEM pipeline latch plus the data-cache request FSM (IDLE -> REQ -> DONE).
// Latency: one CLK edge for non-memory ops; memory ops take 1 + cycles until dhit.
// Backpressure: mem_stall holds upstream while a request waits; it drops in the dhit cycle.
// Ports: CLK/RST (sync active-high); ihit/flush capture controls; dhit/dmemload cache
//        response; ex_* execute results in; dmem* cache request out; mem_* writeback
//        latch out; mem_stall upstream freeze; fwd_* forwarding source.
module iexec_mmem
    import cpu_types_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    input  logic     ihit,
    input  logic     flush,
    input  logic     dhit,
    input  word_t    dmemload,
    input  logic     ex_valid,
    input  logic     ex_dREN,
    input  logic     ex_dWEN,
    input  logic     ex_RegWr,
    input  logic     ex_MemtoReg,
    input  logic     ex_halt,
    input  word_t    ex_alu_out,
    input  word_t    ex_rdat2,
    input  word_t    ex_pcplusfour,
    input  regbits_t ex_wsel,
    output logic     dmemREN,
    output logic     dmemWEN,
    output word_t    dmemaddr,
    output word_t    dmemstore,
    output logic     mem_valid,
    output logic     mem_RegWr,
    output logic     mem_MemtoReg,
    output logic     mem_halt,
    output word_t    mem_alu_out,
    output word_t    mem_load,
    output word_t    mem_pcplusfour,
    output regbits_t mem_wsel,
    output logic     mem_stall,
    output logic     fwd_valid,
    output regbits_t fwd_wsel,
    output word_t    fwd_data
);

    memstate_t state_q, state_d;
    logic      valid_q, valid_d;
    logic      dren_q, dren_d;
    logic      dwen_q, dwen_d;
    logic      regwr_q, regwr_d;
    logic      m2r_q, m2r_d;
    logic      halt_q, halt_d;
    word_t     alu_q, alu_d;
    word_t     rdat2_q, rdat2_d;
    word_t     load_q, load_d;
    word_t     pc4_q, pc4_d;
    regbits_t  wsel_q, wsel_d;

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        dren_d  = dren_q;
        dwen_d  = dwen_q;
        regwr_d = regwr_q;
        m2r_d   = m2r_q;
        halt_d  = halt_q;
        alu_d   = alu_q;
        rdat2_d = rdat2_q;
        load_d  = load_q;
        pc4_d   = pc4_q;
        wsel_d  = wsel_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (ihit) begin
                    alu_d   = ex_alu_out;
                    rdat2_d = ex_rdat2;
                    pc4_d   = ex_pcplusfour;
                    wsel_d  = ex_wsel;
                    m2r_d   = ex_MemtoReg;
                    if (flush || halt_q) begin
                        // Bubble; once halted the halt flag stays up until reset.
                        valid_d = 1'b0;
                        regwr_d = 1'b0;
                        dren_d  = 1'b0;
                        dwen_d  = 1'b0;
                        halt_d  = halt_q;
                    end else begin
                        valid_d = ex_valid;
                        regwr_d = ex_RegWr;
                        dren_d  = ex_valid & ex_dREN;
                        dwen_d  = ex_valid & ex_dWEN;
                        halt_d  = ex_valid & ex_halt;
                    end
                    state_d = (dren_d || dwen_d) ? REQ : IDLE;
                end
            end
            REQ: begin
                // Waiting on the cache: ihit and flush have no effect on the in-flight op.
                if (dhit) begin
                    state_d = DONE;
                    if (dren_q) begin
                        load_d = dmemload;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
            regwr_q <= 1'b0;
            m2r_q   <= 1'b0;
            halt_q  <= 1'b0;
            alu_q   <= '0;
            rdat2_q <= '0;
            load_q  <= '0;
            pc4_q   <= '0;
            wsel_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dren_q  <= dren_d;
            dwen_q  <= dwen_d;
            regwr_q <= regwr_d;
            m2r_q   <= m2r_d;
            halt_q  <= halt_d;
            alu_q   <= alu_d;
            rdat2_q <= rdat2_d;
            load_q  <= load_d;
            pc4_q   <= pc4_d;
            wsel_q  <= wsel_d;
        end
    end

    assign dmemREN   = (state_q == REQ) & dren_q;
    assign dmemWEN   = (state_q == REQ) & dwen_q;
    assign dmemaddr  = {alu_q[31:2], 2'b00};
    assign dmemstore = rdat2_q;

    assign mem_valid      = valid_q;
    assign mem_RegWr      = regwr_q;
    assign mem_MemtoReg   = m2r_q;
    assign mem_halt       = halt_q;
    assign mem_alu_out    = alu_q;
    assign mem_load       = load_q;
    assign mem_pcplusfour = pc4_q;
    assign mem_wsel       = wsel_q;

    // Combinational on dhit so upstream is released in the same cycle the cache answers.
    assign mem_stall = (state_q == REQ) & ~dhit;

    // A result still waiting on the cache is not forwardable yet.
    assign fwd_valid = valid_q & regwr_q & (wsel_q != '0) & (state_q != REQ);
    assign fwd_wsel  = wsel_q;
    assign fwd_data  = (m2r_q && state_q == DONE) ? load_q : alu_q;

endmodule

// File: tb/tb_iexec_mmem.sv
module tb_iexec_mmem;
    import cpu_types_pkg::*;

    logic     CLK = 1'b0;
    logic     RST, ihit, flush, dhit;
    word_t    dmemload;
    logic     ex_valid, ex_dREN, ex_dWEN, ex_RegWr, ex_MemtoReg, ex_halt;
    word_t    ex_alu_out, ex_rdat2, ex_pcplusfour;
    regbits_t ex_wsel;
    logic     dmemREN, dmemWEN;
    word_t    dmemaddr, dmemstore;
    logic     mem_valid, mem_RegWr, mem_MemtoReg, mem_halt;
    word_t    mem_alu_out, mem_load, mem_pcplusfour;
    regbits_t mem_wsel;
    logic     mem_stall, fwd_valid;
    regbits_t fwd_wsel;
    word_t    fwd_data;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    iexec_mmem dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .flush(flush), .dhit(dhit), .dmemload(dmemload),
        .ex_valid(ex_valid), .ex_dREN(ex_dREN), .ex_dWEN(ex_dWEN), .ex_RegWr(ex_RegWr),
        .ex_MemtoReg(ex_MemtoReg), .ex_halt(ex_halt), .ex_alu_out(ex_alu_out),
        .ex_rdat2(ex_rdat2), .ex_pcplusfour(ex_pcplusfour), .ex_wsel(ex_wsel),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .mem_valid(mem_valid), .mem_RegWr(mem_RegWr), .mem_MemtoReg(mem_MemtoReg),
        .mem_halt(mem_halt), .mem_alu_out(mem_alu_out), .mem_load(mem_load),
        .mem_pcplusfour(mem_pcplusfour), .mem_wsel(mem_wsel), .mem_stall(mem_stall),
        .fwd_valid(fwd_valid), .fwd_wsel(fwd_wsel), .fwd_data(fwd_data)
    );

    typedef struct {
        logic        ihit, flush, dhit, valid, dren, dwen, regwr, m2r;
        logic [4:0]  wsel;
        logic [31:0] alu, ld;
        logic        e_valid, e_ren, e_wen, e_stall, e_fwd;
        logic [31:0] e_fdata, e_addr;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        ihit = 0; flush = 0; dhit = 0;
    endtask

    task automatic set_ex(input logic v, input logic rd, input logic wr, input logic rw,
                          input logic m2r, input logic hlt, input logic [4:0] ws,
                          input logic [31:0] alu, input logic [31:0] r2);
        ex_valid = v; ex_dREN = rd; ex_dWEN = wr; ex_RegWr = rw; ex_MemtoReg = m2r;
        ex_halt = hlt; ex_wsel = ws; ex_alu_out = alu; ex_rdat2 = r2;
    endtask

    int stall_cnt, wen_after, ren_cnt;

    initial begin
        // ihit flush dhit valid dren dwen regwr m2r wsel alu ld | valid ren wen stall fwd fdata addr
        vecs[0]  = '{1,0,0,1,0,0,1,0,5'd5,32'h7,    32'h0,       1,0,0,0,1,32'h7,        32'h4};
        vecs[1]  = '{0,0,0,1,0,0,1,0,5'd5,32'h9,    32'h0,       1,0,0,0,1,32'h7,        32'h4};
        vecs[2]  = '{1,0,0,1,0,0,1,0,5'd0,32'h10,   32'h0,       1,0,0,0,0,32'h10,       32'h10};
        vecs[3]  = '{1,1,0,1,0,0,1,0,5'd3,32'h10,   32'h0,       0,0,0,0,0,32'h10,       32'h10};
        vecs[4]  = '{1,0,0,1,1,0,1,1,5'd8,32'h1003, 32'h0,       1,1,0,1,0,32'h1003,     32'h1000};
        vecs[5]  = '{0,0,0,0,0,0,0,0,5'd0,32'h0,    32'h0,       1,1,0,1,0,32'h1003,     32'h1000};
        vecs[6]  = '{0,0,1,0,0,0,0,0,5'd0,32'h0,    32'hCAFEF00D,1,0,0,0,1,32'hCAFEF00D, 32'h1000};
        vecs[7]  = '{1,1,0,1,1,0,1,1,5'd8,32'h1003, 32'h0,       0,0,0,0,0,32'h1003,     32'h1000};
        vecs[8]  = '{0,0,0,0,0,0,0,0,5'd0,32'h0,    32'h0,       0,0,0,0,0,32'h1003,     32'h1000};
        vecs[9]  = '{1,0,0,1,0,1,0,0,5'd0,32'h20,   32'h0,       1,0,1,1,0,32'h20,       32'h20};
        vecs[10] = '{0,0,1,0,0,0,0,0,5'd0,32'h0,    32'h0,       1,0,0,0,0,32'h20,       32'h20};

        RST = 1; clr(); dmemload = '0; ex_pcplusfour = 32'h404;
        set_ex(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        tick(); tick();
        RST = 0;
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_dmemREN",   32'(dmemREN),   32'd0);
        chk("rst_dmemWEN",   32'(dmemWEN),   32'd0);
        chk("rst_stall",     32'(mem_stall), 32'd0);
        chk("rst_fwd_valid", 32'(fwd_valid), 32'd0);
        chk("rst_mem_halt",  32'(mem_halt),  32'd0);
        chk("rst_mem_load",  mem_load,       32'h0);

        for (int i = 0; i < 11; i++) begin
            ihit = vecs[i].ihit; flush = vecs[i].flush; dhit = vecs[i].dhit;
            dmemload = vecs[i].ld;
            set_ex(vecs[i].valid, vecs[i].dren, vecs[i].dwen, vecs[i].regwr, vecs[i].m2r, 0,
                   vecs[i].wsel, vecs[i].alu, 32'h0);
            tick(); clr(); #1;
            chk($sformatf("v%0d_mem_valid", i), 32'(mem_valid), 32'(vecs[i].e_valid));
            chk($sformatf("v%0d_dmemREN", i),   32'(dmemREN),   32'(vecs[i].e_ren));
            chk($sformatf("v%0d_dmemWEN", i),   32'(dmemWEN),   32'(vecs[i].e_wen));
            chk($sformatf("v%0d_stall", i),     32'(mem_stall), 32'(vecs[i].e_stall));
            chk($sformatf("v%0d_fwd_valid", i), 32'(fwd_valid), 32'(vecs[i].e_fwd));
            chk($sformatf("v%0d_fwd_data", i),  fwd_data,       vecs[i].e_fdata);
            chk($sformatf("v%0d_dmemaddr", i),  dmemaddr,       vecs[i].e_addr);
        end
        chk("alu_pcplusfour", mem_pcplusfour, 32'h404);

        // Load with three wait cycles; dhit arrives together with ihit.
        set_ex(1, 1, 0, 1, 1, 0, 5'd9, 32'h1003, 32'h0);
        ihit = 1; tick(); clr();
        set_ex(0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0);
        stall_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (mem_stall) stall_cnt++;
            chk("ld_wait_addr", dmemaddr, 32'h1000);
            tick();
        end
        dhit = 1; dmemload = 32'hDEADBEEF; ihit = 1;
        set_ex(1, 0, 0, 1, 0, 0, 5'd2, 32'h44, 32'h0);
        #1;
        chk("ld_stall_release", 32'(mem_stall), 32'd0);
        tick(); clr();
        chk("ld_stall_cycles", 32'(stall_cnt), 32'd3);
        chk("ld_mem_load",     mem_load,       32'hDEADBEEF);
        chk("ld_fwd_data",     fwd_data,       32'hDEADBEEF);
        chk("ld_fwd_wsel",     32'(fwd_wsel),  32'd9);
        chk("ld_fwd_valid",    32'(fwd_valid), 32'd1);
        chk("ld_req_dropped",  32'(dmemREN),   32'd0);
        ihit = 1; tick(); clr();
        chk("after_done_fwd_data", fwd_data,      32'h44);
        chk("after_done_fwd_wsel", 32'(fwd_wsel), 32'd2);

        // Store: request held until dhit, ihit ignored while waiting, never reissued.
        set_ex(1, 0, 1, 0, 0, 0, 5'd0, 32'h20, 32'h12345678);
        ihit = 1; tick(); clr();
        set_ex(1, 0, 0, 1, 0, 0, 5'd6, 32'h88, 32'h0);
        for (int c = 0; c < 2; c++) begin
            chk("st_wen",   32'(dmemWEN), 32'd1);
            chk("st_store", dmemstore,    32'h12345678);
            chk("st_addr",  dmemaddr,     32'h20);
            ihit = 1; flush = c[0];
            tick(); clr();
        end
        dhit = 1; tick(); clr();
        wen_after = 0;
        for (int c = 0; c < 4; c++) begin
            if (dmemWEN) wen_after++;
            tick();
        end
        chk("st_no_reissue", 32'(wen_after), 32'd0);
        chk("st_mem_load_kept", mem_load, 32'hDEADBEEF);
        chk("st_valid_kept", 32'(mem_valid), 32'd1);

        // Flush with ihit on a load never requests.
        set_ex(1, 1, 0, 1, 1, 0, 5'd4, 32'h300, 32'h0);
        ihit = 1; flush = 1; tick(); clr();
        ren_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            if (dmemREN) ren_cnt++;
            tick();
        end
        chk("fl_ren_count", 32'(ren_cnt),  32'd0);
        chk("fl_mem_valid", 32'(mem_valid), 32'd0);

        // dhit with flush in REQ still completes the load.
        set_ex(1, 1, 0, 1, 1, 0, 5'd4, 32'h200, 32'h0);
        ihit = 1; tick(); clr();
        chk("dhfl_ren", 32'(dmemREN), 32'd1);
        dhit = 1; flush = 1; dmemload = 32'h55AA55AA; tick(); clr();
        chk("dhfl_mem_valid", 32'(mem_valid), 32'd1);
        chk("dhfl_mem_load",  mem_load,       32'h55AA55AA);
        chk("dhfl_fwd_valid", 32'(fwd_valid), 32'd1);
        chk("dhfl_fwd_data",  fwd_data,       32'h55AA55AA);

        // Reset mid-REQ dominates ihit and dhit.
        set_ex(1, 1, 0, 1, 1, 0, 5'd7, 32'h400, 32'h0);
        ihit = 1; tick(); clr();
        chk("rq_ren", 32'(dmemREN), 32'd1);
        set_ex(1, 0, 0, 1, 0, 0, 5'd3, 32'h99, 32'h0);
        RST = 1; ihit = 1; dhit = 1; dmemload = 32'h11111111; tick(); RST = 0; clr(); #1;
        chk("rq_rst_ren",       32'(dmemREN),   32'd0);
        chk("rq_rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rq_rst_stall",     32'(mem_stall), 32'd0);
        chk("rq_rst_mem_load",  mem_load,       32'h0);
        ihit = 1; tick(); clr();
        chk("rq_idle_capture", 32'(fwd_valid), 32'd1);
        chk("rq_idle_data",    fwd_data,       32'h99);

        // Halt is sticky and turns later captures into bubbles.
        set_ex(1, 0, 0, 0, 0, 1, 5'd0, 32'h0, 32'h0);
        ihit = 1; tick(); clr();
        chk("halt_set", 32'(mem_halt), 32'd1);
        set_ex(1, 1, 0, 1, 1, 0, 5'd5, 32'h1000, 32'h0);
        ihit = 1; tick(); clr();
        chk("halt_sticky",    32'(mem_halt),  32'd1);
        chk("halt_ren",       32'(dmemREN),   32'd0);
        chk("halt_bubble",    32'(mem_valid), 32'd0);
        tick();
        chk("halt_ren_later", 32'(dmemREN),   32'd0);
        chk("halt_hold",      32'(mem_halt),  32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
